srambank_ctrl_64x4x80: RTL and testbench

SRAMBANK_CTRL_64X4X80 -- requirements
Module: srambank_ctrl_64x4x80

---
 rtl/srambank_ctrl_64x4x80_if.sv | 22 ++
 rtl/srambank_ctrl_64x4x80.sv | 76 +++++++
 tb/tb_srambank_ctrl_64x4x80.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srambank_ctrl_64x4x80_if.sv
// Request/response bus of the SRAM bank controller.
// Handshake: a beat transfers at posedge clk when valid & ready are both 1; the sender holds its payload stable until then.
interface srambank_ctrl_64x4x80_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [79:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [79:0] rsp_data;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/srambank_ctrl_64x4x80.sv
// SRAM bank controller: drives the bank straight from the request and returns read data
// through a 4-entry response FIFO, with saturating write/read counters.
module srambank_ctrl_64x4x80 (
   input  logic                          clk,
   input  logic                          reset,
   srambank_ctrl_64x4x80_if.slave        bus,
   output logic [7:0]                    ADDRESS,
   output logic [79:0]                   wd,
   output logic                          banksel,
   output logic                          read,
   output logic                          write,
   input  logic [79:0]                   dataout,
   output logic [15:0]                   wr_count,
   output logic [15:0]                   rd_count
);

   logic        accept;
   logic        push;
   logic        pop;
   logic        inflight;
   logic [2:0]  count;
   logic [3:0]  occupancy;
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [79:0] fifo_mem [4];

   // Reserving a slot for the in-flight read guarantees the push never finds the FIFO full.
   assign occupancy     = {1'b0, count} + {3'b000, inflight};
   assign bus.req_ready = ~reset & (occupancy < 4'd4);
   assign accept        = bus.req_valid & bus.req_ready;

   assign ADDRESS = bus.req_addr;
   assign wd      = bus.req_wdata;
   assign banksel = accept;
   assign write   = accept & bus.req_write;
   assign read    = accept & ~bus.req_write;

   assign push          = inflight;
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign bus.rsp_valid = (count != 3'd0);
   assign bus.rsp_data  = fifo_mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= 1'b0;
         count    <= 3'd0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
      end else begin
         inflight <= read;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Bank output is registered, so it is valid exactly one cycle after the read accept.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= dataout;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count <= 16'd0;
         rd_count <= 16'd0;
      end else begin
         if (write && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
         if (read && (rd_count != 16'hFFFF))  rd_count <= rd_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_srambank_ctrl_64x4x80.sv
// Bench for srambank_ctrl_64x4x80: bank model, reference memory with expected-response
// queue, directed scenarios followed by randomized traffic.
module tb_srambank_ctrl_64x4x80;

   logic        clk;
   logic        reset;
   logic [7:0]  ADDRESS;
   logic [79:0] wd;
   logic        banksel;
   logic        read;
   logic        write;
   logic [79:0] dataout;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   srambank_ctrl_64x4x80_if bus ();

   srambank_ctrl_64x4x80 dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .ADDRESS  (ADDRESS),
      .wd       (wd),
      .banksel  (banksel),
      .read     (read),
      .write    (write),
      .dataout  (dataout),
      .wr_count (wr_count),
      .rd_count (rd_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bank model (registered read port) ----------------
   bit [79:0] bank_mem [256];
   initial dataout = '0;
   always @(posedge clk) begin
      if (banksel && write) bank_mem[ADDRESS] <= wd;
      if (banksel && read)  dataout <= bank_mem[ADDRESS];
   end

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   int          rsp_seen = 0;
   bit [79:0]   ref_mem [256];
   logic [79:0] exp_q [$];
   logic [15:0] wr_exp = 16'd0;
   logic [15:0] rd_exp = 16'd0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor: model compare at negedge ----------------
   always @(negedge clk) begin
      logic        exp_ready;
      logic        acc;
      logic [79:0] head;
      if (reset) begin
         check("reset_req_ready", 80'(bus.req_ready), 80'd0);
         check("reset_rsp_valid", 80'(bus.rsp_valid), 80'd0);
         check("reset_bank_en", 80'({banksel, read, write}), 80'd0);
         exp_q.delete();
         wr_exp = 16'd0;
         rd_exp = 16'd0;
      end else begin
         // Outstanding reads = accepted but not yet consumed; at most four allowed.
         exp_ready = (exp_q.size() < 4);
         acc = bus.req_valid && exp_ready;
         check("req_ready", 80'(bus.req_ready), 80'(exp_ready));
         check("wr_count", 80'(wr_count), 80'(wr_exp));
         check("rd_count", 80'(rd_count), 80'(rd_exp));
         check("banksel", 80'(banksel), 80'(acc));
         check("bank_write", 80'(write), 80'(acc && bus.req_write));
         check("bank_read", 80'(read), 80'(acc && !bus.req_write));
         check("bank_addr", 80'(ADDRESS), 80'(bus.req_addr));
         check("bank_wd", wd, bus.req_wdata);
         if (bus.rsp_valid && exp_q.size() == 0) begin
            check("rsp_valid_unexpected", 80'(bus.rsp_valid), 80'd0);
         end else if (bus.rsp_valid && bus.rsp_ready) begin
            head = exp_q.pop_front();
            check("rsp_data", bus.rsp_data, head);
            rsp_seen++;
         end
         if (acc) begin
            if (bus.req_write) begin
               ref_mem[bus.req_addr] = bus.req_wdata;
               if (wr_exp != 16'hFFFF) wr_exp = wr_exp + 16'd1;
            end else begin
               exp_q.push_back(ref_mem[bus.req_addr]);
               if (rd_exp != 16'hFFFF) rd_exp = rd_exp + 16'd1;
            end
         end
      end
   end

   // ---------------- assertions ----------------
   a_excl: assert property (@(posedge clk) !(read && write))
      else begin errors++; $display("FAIL assert_excl read=%0b write=%0b", read, write); end
   a_bsel: assert property (@(posedge clk) banksel == (read || write))
      else begin errors++; $display("FAIL assert_banksel banksel=%0b", banksel); end
   a_hold: assert property (@(posedge clk) disable iff (reset)
                            (bus.rsp_valid && !bus.rsp_ready) |=> $stable(bus.rsp_data))
      else begin errors++; $display("FAIL assert_rsp_hold data=%h", bus.rsp_data); end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit w, input logic [7:0] a, input logic [79:0] d, output int stalls);
      stalls = 0;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      forever begin
         @(negedge clk);
         if (bus.req_ready) begin
            step();
            break;
         end
         step();
         stalls++;
         if (stalls >= 3) bus.rsp_ready = 1'b1;
         if (stalls > 50) begin
            errors++;
            $display("FAIL issue_timeout: req_ready stuck at %0b, expected 1", bus.req_ready);
            break;
         end
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.rsp_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("drain_timeout", 80'(exp_q.size()), 80'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int st;
      int acc_n;
      int seen0;
      logic [7:0] a;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      #1;
      check("reset_async_ready", 80'(bus.req_ready), 80'd0);
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 80'(bus.req_ready), 80'd1);
      step();

      // write then read, latency 2
      issue(1'b1, 8'h05, 80'h1234, st);
      issue(1'b0, 8'h05, 80'h0, st);
      @(negedge clk);
      check("lat_cycle1_rsp_valid", 80'(bus.rsp_valid), 80'd0);
      @(negedge clk);
      check("lat_cycle2_rsp_valid", 80'(bus.rsp_valid), 80'd1);
      check("lat_cycle2_rsp_data", bus.rsp_data, 80'h1234);
      check("wr_count_one", 80'(wr_count), 80'd1);
      check("rd_count_one", 80'(rd_count), 80'd1);
      step();
      drain();

      // streaming reads
      for (int i = 0; i < 8; i++) issue(1'b1, 8'(i), 80'(i * 3), st);
      seen0 = rsp_seen;
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 8'(i), 80'h0, st);
         check("stream_no_stall", 80'(st), 80'd0);
      end
      step();
      step();
      check("stream_consecutive", 80'(rsp_seen - seen0), 80'd8);

      // backpressure
      drain();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      a = 8'd0;
      acc_n = 0;
      bus.req_addr = a;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            acc_n++;
            step();
            a = a + 8'd1;
            bus.req_addr = a;
         end else begin
            step();
         end
      end
      @(negedge clk);
      check("bp_accepted", 80'(acc_n), 80'd4);
      check("bp_ready_low", 80'(bus.req_ready), 80'd0);
      check("bp_banksel_low", 80'(banksel), 80'd0);
      step();
      bus.req_valid = 1'b0;
      seen0 = rsp_seen;
      bus.rsp_ready = 1'b1;
      repeat (8) step();
      check("bp_responses", 80'(rsp_seen - seen0), 80'd4);
      @(negedge clk);
      check("bp_ready_back", 80'(bus.req_ready), 80'd1);
      step();

      // reset mid-operation
      issue(1'b0, 8'h03, 80'h0, st);
      reset = 1'b1;
      #1;
      check("rst_mid_ready", 80'(bus.req_ready), 80'd0);
      check("rst_mid_rsp_valid", 80'(bus.rsp_valid), 80'd0);
      repeat (2) step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_after_rsp_valid", 80'(bus.rsp_valid), 80'd0);
      check("rst_after_wr_count", 80'(wr_count), 80'd0);
      check("rst_after_rd_count", 80'(rd_count), 80'd0);
      repeat (4) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) step();
         else issue($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)),
                    {16'($urandom), $urandom, $urandom}, st);
      end
      drain();

      // write counter saturation
      apply_reset();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         bus.req_addr  = 8'($urandom);
         bus.req_wdata = {16'($urandom), $urandom, $urandom};
         step();
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("sat_at_max", 80'(wr_count), 80'hFFFF);
      step();
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("sat_hold", 80'(wr_count), 80'hFFFF);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
